// File: rtl/fetch_stage.sv
// Instruction fetch stage: tracks the fetch PC, issues in-order imem requests, buffers
// responses in a 2-entry queue, and drives the IF/ID register consumed by decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        id_flush
);

    localparam logic [1:0] MaxOut = 2'(MAX_OUTSTANDING);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [1:0]       outstanding_q, outstanding_d;
    logic [1:0]       discard_q, discard_d;
    logic [1:0]       count_q, count_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0][31:0] fq_pc_q, fq_pc_d;
    logic [1:0][31:0] fq_instr_q, fq_instr_d;
    logic [1:0][31:0] tag_pc_q, tag_pc_d;
    logic             tag_rd_q, tag_rd_d;
    logic             tag_wr_q, tag_wr_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic             flush_q, flush_d;

    logic [2:0]  live;
    logic        issue;
    logic        resp_keep;
    logic        bypass;
    logic        push;
    logic        pop;
    logic [31:0] resp_pc;
    logic        unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // live counts queued words plus in-flight words that will actually be kept
    always_comb begin
        live      = 3'(count_q) + 3'(outstanding_q) - 3'(discard_q);
        issue     = rst_n && !redirect_valid && (live < 3'd2) && (outstanding_q < MaxOut);
        resp_pc   = tag_pc_q[tag_rd_q];
        resp_keep = imem_rvalid && (discard_q == 2'd0) && !redirect_valid;
        pop       = !redirect_valid && !stall_in && (count_q != 2'd0);
        bypass    = resp_keep && !stall_in && (count_q == 2'd0);
        push      = resp_keep && !bypass;
    end

    assign imem_req        = issue;
    assign imem_addr       = fetch_pc_q;
    assign instruction_out = instr_q;
    assign pc_out          = pc_q;
    assign id_flush        = flush_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fq_pc_d       = fq_pc_q;
        fq_instr_d    = fq_instr_q;
        tag_pc_d      = tag_pc_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        flush_d       = flush_q;

        // Tag FIFO mirrors every request, including ones later discarded
        if (issue) begin
            fetch_pc_d         = fetch_pc_q + 32'd4;
            tag_pc_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d           = ~tag_wr_q;
            outstanding_d      = outstanding_d + 2'd1;
        end
        if (imem_rvalid) begin
            tag_rd_d      = ~tag_rd_q;
            outstanding_d = outstanding_d - 2'd1;
        end

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            discard_d  = outstanding_q - {1'b0, imem_rvalid};
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            instr_d    = 32'h0;
            flush_d    = 1'b1;
        end else begin
            if (imem_rvalid && (discard_q != 2'd0)) begin
                discard_d = discard_q - 2'd1;
            end
            if (push) begin
                fq_pc_d[wr_ptr_q]    = resp_pc;
                fq_instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d             = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end

            if (!stall_in) begin
                if (count_q != 2'd0) begin
                    instr_d = fq_instr_q[rd_ptr_q];
                    pc_d    = fq_pc_q[rd_ptr_q];
                    flush_d = 1'b0;
                end else if (bypass) begin
                    instr_d = imem_rdata;
                    pc_d    = resp_pc;
                    flush_d = 1'b0;
                end else begin
                    instr_d = 32'h0;
                    flush_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            fq_pc_q       <= '0;
            fq_instr_q    <= '0;
            tag_pc_q      <= '0;
            tag_rd_q      <= 1'b0;
            tag_wr_q      <= 1'b0;
            instr_q       <= 32'h0;
            pc_q          <= 32'h0;
            flush_q       <= 1'b1;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fq_pc_q       <= fq_pc_d;
            fq_instr_q    <= fq_instr_d;
            tag_pc_q      <= tag_pc_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            flush_q       <= flush_d;
        end
    end

    // A full queue with no pop must never receive a word
    assert property (@(posedge clk) disable iff (!rst_n) !(push && (count_q == 2'd2) && !pop));

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage directly upstream of the decode unit. Maintains the fetch PC, issues in-order requests to instruction memory with up to two outstanding, buffers returned words in a 2-entry fetch queue, and drives the IF/ID pipeline register (`instruction_out`, `pc_out`, `id_flush`) consumed by decode. It honours back-pressure from ID (`stall_in`) and redirects from EX (`redirect_valid`). A redirect kills wrong-path work: queue contents, in-flight responses, and the IF/ID register.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `MAX_OUTSTANDING`, default 2: max in-flight imem requests. Legal values 1..2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `imem_req`  out  1  request valid; memory accepts every asserted cycle (no grant).
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_rvalid`  in  1  response valid; responses return in request order, latency >= 1 cycle.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `stall_in`  in  1  ID stall: hold the IF/ID register.
- `redirect_valid`  in  1  taken branch or jump from EX.
- `redirect_pc`  in  32  target PC; bits [1:0] ignored and treated as 0.
- `instruction_out`  out  32  IF/ID instruction; 32'h0 when bubble.
- `pc_out`  out  32  IF/ID PC of `instruction_out`.
- `id_flush`  out  1  1 = IF/ID holds a bubble; decode treats the instruction as NOP.

## Operation
- **State**
  - `fetch_pc`: 32 bits.
  - `outstanding`: 0..2.
  - `discard`: 0..2, in-flight responses to drop.
  - Queue: 2 entries of {pc, instr}, with rd ptr, wr ptr and count 0..2.
  - IF/ID register: instr, pc, flush.
- **Issue**
  - `imem_req` = !`redirect_valid` && (count + `outstanding` - `discard`) < 2 && `outstanding` < MAX_OUTSTANDING.
  - `imem_addr` = `fetch_pc`.
  - On an issue edge, `fetch_pc` += 4 (mod 2^32; wrap 32'hFFFF_FFFC -> 0 is legal) and `outstanding`++.
  - The PC of each request is tracked in a 2-entry in-order tag FIFO so the queue entry carries the correct PC.
- **Response**
  - `imem_rvalid` decrements `outstanding`.
  - If `discard` > 0: decrement `discard` and drop the word.
  - Otherwise the word is written to the queue.
  - Bypass: if the queue is empty, `stall_in` = 0, and no redirect, the word loads straight into IF/ID at the same edge.
- **IF/ID load**
  - When `stall_in` = 0: load the queue head (pop) if count > 0, else the bypass word, else a bubble (instr 0, `id_flush` = 1).
  - When `stall_in` = 1: hold all three fields.
- **Redirect** (highest priority, same edge)
  - `fetch_pc` <= `redirect_pc` & ~3.
  - Queue cleared.
  - `discard` <= `outstanding` minus any response arriving this cycle.
  - IF/ID <= bubble, regardless of `stall_in`.
  - No request is issued in the redirect cycle.
- **Simultaneous events**
  - Redirect + `rvalid`: the word is dropped and not counted in the new `discard`.
  - Redirect + `stall_in`: redirect wins.
  - Push and pop in the same cycle: count unchanged.
- **Reset** (async, any time including mid-transaction)
  - `fetch_pc` = RESET_PC.
  - `outstanding` = `discard` = count = 0, pointers = 0.
  - `instruction_out` = 0, `pc_out` = 0, `id_flush` = 1, `imem_req` = 0.
  - Responses to requests issued before reset are a system error and outside scope; memory is reset with the same `rst_n`.
- **Overflow**
  - The issue rule guarantees the queue never overflows.
  - Assertion: a push when count = 2 and no pop is an error.

## Timing
- Cycle 0 after `rst_n` rises: `imem_req` = 1, `imem_addr` = RESET_PC.
- Response latency L: the word appears on `instruction_out` at the edge that samples `imem_rvalid` (bypass), so it is visible in cycle L.
- Steady state with L = 1 and no stalls: one instruction per cycle. `pc_out` increments by 4 every cycle.
- Redirect at edge E:
  - `id_flush` = 1 after E.
  - The new request is issued in the cycle after E.
  - The first target instruction appears after (1 + L) cycles, plus any cycles spent draining `discard`.
  - Discarded responses do not stall issue beyond the outstanding limit.
- Stall: the IF/ID register holds. The queue fills to 2, then `imem_req` deasserts.
- When the stall releases: one queue pop per cycle. Issue resumes in the same cycle count drops, per the combinational rule.

## Test plan
- **Reset/stream:** RESET_PC = 0x100, L = 1, memory returns word = addr. Required: `pc_out` 0x100, 0x104, 0x108… on consecutive cycles, `instruction_out` = `pc_out`, `id_flush` = 0 from cycle 1.
- **Stall:** assert `stall_in` for 5 cycles mid-stream while `pc_out` = 0x108. Required: `pc_out` held at 0x108, count reaches 2, `imem_req` = 0. After release: 0x10C, 0x110, 0x114 with no gap or duplicate.
- **Redirect with in-flight:** L = 3, redirect to 0x2002 while 2 requests are outstanding. Required: both old responses dropped, `id_flush` = 1 until 0x2000 appears, first `imem_addr` after redirect = 0x2000.
- **Simultaneous redirect + rvalid + stall:** required: the arriving word is dropped, IF/ID becomes a bubble, `discard` = 1 if one request remains, and the next valid `pc_out` = target.
- **Wrap-around:** redirect to 0xFFFF_FFF8. Required: `pc_out` 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Async reset mid-stream:** drop `rst_n` between edges. Required: outputs immediately return to 0 / 0 / `id_flush` = 1 and `imem_req` = 0. After release, fetch restarts at RESET_PC.
